// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one memory request at a time from the PC,
// buffers returned instructions in a small circular FIFO, and discards
// responses belonging to requests flushed by a branch or abandoned by reset.
module instruction_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_1000,
  parameter logic [31:0] MAX_ADDR   = 32'h0000_2000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_current,
  input  logic        branch_taken,
  output logic        pc_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

  localparam int unsigned     PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned     CntW     = PtrW + 1;
  localparam logic [PtrW-1:0] PtrMax   = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(FIFO_DEPTH);
  localparam logic [31:0]     NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StWait, StDrop, StFault} state_e;

  state_e                          state_q, state_d;
  logic [31:0]                     req_pc_q, req_pc_d;
  logic [PtrW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]                 count_q, count_d;
  logic [FIFO_DEPTH-1:0][31:0]     fifo_pc_q, fifo_pc_d;
  logic [FIFO_DEPTH-1:0][31:0]     fifo_instr_q, fifo_instr_d;
  logic [FIFO_DEPTH-1:0]           fifo_fault_q, fifo_fault_d;

  logic        room;
  logic        pc_ok;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic        push_fault;

  assign room          = (count_q < CntMax);
  assign pc_ok         = (pc_current[1:0] == 2'b00) && (pc_current < MAX_ADDR);
  assign accept        = imem_req_valid && imem_req_ready;
  assign imem_req_addr = pc_current;
  // The PC only moves on an accepted fetch or a branch redirect; reset holds it.
  assign pc_stall      = !rst_n || !(accept || branch_taken);

  assign if_valid = (count_q != '0);
  assign if_pc    = fifo_pc_q[rd_ptr_q];
  assign if_instr = fifo_instr_q[rd_ptr_q];
  assign if_fault = fifo_fault_q[rd_ptr_q];
  assign pop      = if_valid && if_ready && !branch_taken;

  // Fetch FSM: next state, request valid and the single-entry push it produces.
  always_comb begin
    state_d        = state_q;
    req_pc_d       = req_pc_q;
    imem_req_valid = 1'b0;
    push           = 1'b0;
    push_pc        = pc_current;
    push_instr     = imem_rsp_data;
    push_fault     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          // Any response seen here is stale (from before a reset) and is dropped.
          if (!branch_taken && room) begin
            if (pc_ok) begin
              imem_req_valid = 1'b1;
              if (imem_req_ready) begin
                req_pc_d = pc_current;
                state_d  = StWait;
              end
            end else begin
              push       = 1'b1;
              push_instr = NopInstr;
              push_fault = 1'b1;
              state_d    = StFault;
            end
          end
        end
        StWait: begin
          if (branch_taken) begin
            state_d = imem_rsp_valid ? StIdle : StDrop;
          end else if (imem_rsp_valid) begin
            push    = 1'b1;
            push_pc = req_pc_q;
            state_d = StIdle;
          end
        end
        StDrop: begin
          if (imem_rsp_valid) begin
            state_d = StIdle;
          end
        end
        StFault: begin
          if (branch_taken) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Circular buffer bookkeeping; a branch empties it and suppresses push/pop.
  always_comb begin
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    fifo_fault_d = fifo_fault_q;
    if (branch_taken) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = push_pc;
        fifo_instr_d[wr_ptr_q] = push_instr;
        fifo_fault_d[wr_ptr_q] = push_fault;
        wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      req_pc_q <= RESET_ADDR;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Buffer payload needs no reset: it is only observed when count is non-zero.
  always_ff @(posedge clk) begin
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
    fifo_fault_q <= fifo_fault_d;
  end

  // Simulation sanity: legal parameters and no buffer overflow.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count_q <= CntMax);
      assert ((RESET_ADDR < MAX_ADDR) && (RESET_ADDR[1:0] == 2'b00));
      assert ((FIFO_DEPTH == 2) || (FIFO_DEPTH == 4));
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios driving a PC model and a
// fixed-latency memory, with a queue-based reference checked every cycle.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_ADDR = 32'h0000_1000;
  localparam logic [31:0] MAX_ADDR   = 32'h0000_2000;
  localparam int          DEPTH      = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_DROP  = 2;
  localparam int M_FAULT = 3;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_current;
  logic        branch_taken;
  logic        pc_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  int n_checks = 0;
  int n_errors = 0;

  // Environment state.
  logic [31:0] br_target;
  int          mem_lat;
  int          pend;
  logic [31:0] rsp_pc;
  logic        s_adv, s_acc, s_rst, s_br;
  logic [31:0] s_addr;

  // Reference model state.
  int    m_mode;
  logic [31:0] m_req_pc;
  ent_t  mq[$];

  instruction_fetch #(
    .RESET_ADDR(RESET_ADDR),
    .MAX_ADDR  (MAX_ADDR),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_current    (pc_current),
    .branch_taken  (branch_taken),
    .pc_stall      (pc_stall),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_fault      (if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_for(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h0050_0093;
    return {a[15:0], 16'h0013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // What the outputs must be this cycle, from the model state and current inputs.
  task automatic compare_model();
    logic ok, room, e_req, e_stall, e_ifv;
    ok      = (pc_current[1:0] == 2'b00) && (pc_current < MAX_ADDR);
    room    = (mq.size() < DEPTH);
    e_req   = rst_n && (m_mode == M_IDLE) && !branch_taken && ok && room;
    e_stall = !rst_n || !((e_req && imem_req_ready) || branch_taken);
    e_ifv   = (mq.size() != 0);
    chk("cyc_req_valid", 32'(imem_req_valid), 32'(e_req));
    chk("cyc_pc_stall", 32'(pc_stall), 32'(e_stall));
    chk("cyc_if_valid", 32'(if_valid), 32'(e_ifv));
    if (e_req) chk("cyc_req_addr", imem_req_addr, pc_current);
    if (e_ifv) begin
      chk("cyc_if_pc", if_pc, mq[0].pc);
      chk("cyc_if_instr", if_instr, mq[0].instr);
      chk("cyc_if_fault", 32'(if_fault), 32'(mq[0].fault));
    end
  endtask

  // Advance the reference model by one clock edge.
  task automatic model_update();
    logic ok, room, do_pop, do_push;
    ent_t e;
    ok      = (pc_current[1:0] == 2'b00) && (pc_current < MAX_ADDR);
    room    = (mq.size() < DEPTH);
    do_push = 1'b0;
    e       = '{pc: pc_current, instr: NOP, fault: 1'b1};
    if (!rst_n) begin
      m_mode = M_IDLE;
      mq.delete();
    end else if (branch_taken) begin
      if ((m_mode == M_WAIT || m_mode == M_DROP) && !imem_rsp_valid) m_mode = M_DROP;
      else m_mode = M_IDLE;
      mq.delete();
    end else begin
      do_pop = (mq.size() != 0) && if_ready;
      case (m_mode)
        M_IDLE: begin
          if (room && !ok) begin
            do_push = 1'b1;
            m_mode  = M_FAULT;
          end else if (room && imem_req_ready) begin
            m_req_pc = pc_current;
            m_mode   = M_WAIT;
          end
        end
        M_WAIT: begin
          if (imem_rsp_valid) begin
            e       = '{pc: m_req_pc, instr: imem_rsp_data, fault: 1'b0};
            do_push = 1'b1;
            m_mode  = M_IDLE;
          end
        end
        M_DROP: if (imem_rsp_valid) m_mode = M_IDLE;
        default: ;
      endcase
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  endtask

  // Program counter and fixed-latency memory, updated just after each edge.
  task automatic drive_env();
    if (pend > 0) pend--;
    if (s_acc) begin
      pend   = mem_lat;
      rsp_pc = s_addr;
    end
    imem_rsp_valid = (pend == 1);
    imem_rsp_data  = (pend == 1) ? word_for(rsp_pc) : 32'hDEAD_BEEF;
    if (!s_rst) pc_current = RESET_ADDR;
    else if (s_br) pc_current = br_target;
    else if (s_adv) pc_current = pc_current + 32'd4;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_model();
    s_adv  = !pc_stall;
    s_acc  = imem_req_valid && imem_req_ready;
    s_addr = imem_req_addr;
    @(posedge clk);
    s_rst = rst_n;
    s_br  = branch_taken;
    model_update();
    #1;
    drive_env();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_for(input string name, input bit want_req);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (want_req ? (imem_req_valid === 1'b1) : (if_valid === 1'b1)) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s_timeout: event not seen, required within 40 cycles", name);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    branch_taken   = 1'b0;
    br_target      = RESET_ADDR;
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pc_current     = RESET_ADDR;
    mem_lat        = 1;
    pend           = 0;
    rsp_pc         = '0;
    s_adv = 1'b0; s_acc = 1'b0; s_rst = 1'b0; s_br = 1'b0; s_addr = '0;
    m_mode   = M_IDLE;
    m_req_pc = '0;

    @(posedge clk);
    model_update();
    #1;
    drive_env();
    tick();
    settle();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_pc_stall", 32'(pc_stall), 32'd1);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    rst_n = 1'b1;

    // Basic fetch with a 1-cycle memory.
    wait_for("basic", 1'b0);
    chk("basic_if_pc", if_pc, 32'h0000_1000);
    chk("basic_if_instr", if_instr, 32'h0050_0093);

    // Backpressure: two entries fill the buffer, then fetching stops.
    if_ready     = 1'b0;
    branch_taken = 1'b1;
    br_target    = 32'h0000_1000;
    tick();
    branch_taken = 1'b0;
    repeat (10) tick();
    settle();
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_pc_stall", 32'(pc_stall), 32'd1);
    chk("bp_head_pc", if_pc, 32'h0000_1000);
    chk("bp_head_instr", if_instr, 32'h0050_0093);
    if_ready = 1'b1;
    settle();
    chk("bp_pop0_pc", if_pc, 32'h0000_1000);
    tick();
    settle();
    chk("bp_pop1_pc", if_pc, 32'h0000_1004);

    // Flush while a request is outstanding; its response arrives later.
    mem_lat      = 3;
    branch_taken = 1'b1;
    br_target    = 32'h0000_1000;
    tick();
    branch_taken = 1'b0;
    wait_for("flush_req", 1'b1);
    chk("flush_first_addr", imem_req_addr, 32'h0000_1000);
    tick();
    branch_taken = 1'b1;
    br_target    = 32'h0000_1100;
    tick();
    branch_taken = 1'b0;
    wait_for("flush_refetch", 1'b1);
    chk("flush_new_addr", imem_req_addr, 32'h0000_1100);
    chk("flush_if_valid", 32'(if_valid), 32'd0);

    // Flush in the same cycle as the response.
    mem_lat = 2;
    tick();
    tick();
    branch_taken = 1'b1;
    br_target    = 32'h0000_1200;
    tick();
    branch_taken = 1'b0;
    settle();
    chk("coinc_if_valid", 32'(if_valid), 32'd0);
    chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);
    chk("coinc_req_addr", imem_req_addr, 32'h0000_1200);

    // Misaligned PC produces a fault entry and holds the PC.
    if_ready     = 1'b0;
    branch_taken = 1'b1;
    br_target    = 32'h0000_1002;
    tick();
    branch_taken = 1'b0;
    wait_for("fault", 1'b0);
    chk("fault_flag", 32'(if_fault), 32'd1);
    chk("fault_pc", if_pc, 32'h0000_1002);
    chk("fault_instr", if_instr, 32'h0000_0013);
    chk("fault_stall", 32'(pc_stall), 32'd1);
    chk("fault_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (3) tick();
    settle();
    chk("fault_hold_stall", 32'(pc_stall), 32'd1);
    chk("fault_hold_pc", if_pc, 32'h0000_1002);
    if_ready     = 1'b1;
    mem_lat      = 3;
    branch_taken = 1'b1;
    br_target    = 32'h0000_1000;
    tick();
    branch_taken = 1'b0;

    // Reset while waiting; the late response must be ignored.
    wait_for("rst_req", 1'b1);
    tick();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    settle();
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_pc_stall", 32'(pc_stall), 32'd1);
    tick();
    rst_n = 1'b1;
    settle();
    chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
    repeat (2) tick();
    settle();
    chk("stale_if_valid", 32'(if_valid), 32'd0);
    imem_req_ready = 1'b1;
    wait_for("post_rst", 1'b0);
    chk("post_rst_pc", if_pc, 32'h0000_1000);
    chk("post_rst_instr", if_instr, 32'h0050_0093);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h00001000, the PC value at reset; used only for documentation and assertions.
REQ-002 SHALL have parameter MAX_ADDR, default 32'h00002000, the first invalid fetch address.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, the instruction buffer depth; legal values are 2 and 4.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port pc_current  input  32  the current PC from the program counter.
REQ-007 SHALL have port branch_taken  input  1  the redirect/flush request from execute.
REQ-008 SHALL have port pc_stall  output  1  the stall to the program counter (1 = hold PC).
REQ-009 SHALL have port imem_req_valid  output  1  the instruction memory request valid.
REQ-010 SHALL have port imem_req_ready  input  1  the memory request accept.
REQ-011 SHALL have port imem_req_addr  output  32  the request address, equal to pc_current.
REQ-012 SHALL have port imem_rsp_valid  input  1  the response valid; asserted exactly once per accepted request, at least 1 cycle after accept.
REQ-013 SHALL have port imem_rsp_data  input  32  the instruction word.
REQ-014 SHALL have port if_valid  output  1  the decode-side valid.
REQ-015 SHALL have port if_ready  input  1  the decode-side ready.
REQ-016 SHALL have port if_instr  output  32  the instruction at the buffer head.
REQ-017 SHALL have port if_pc  output  32  the PC of if_instr.
REQ-018 SHALL have port if_fault  output  1  set when the head entry is a fetch fault.

Function
REQ-019 SHALL implement an FSM with states IDLE, WAIT (one request outstanding), DROP (flushed request outstanding), and FAULT.
REQ-020 SHALL allow at most one outstanding memory request.
REQ-021 In IDLE, with rst_n=1, branch_taken=0, pc aligned and pc_current<MAX_ADDR, and buffer count<FIFO_DEPTH, SHALL drive imem_req_valid=1.
REQ-022 SHALL drive imem_req_valid combinationally; once it is asserted it SHALL NOT drop until accepted or until branch_taken.
REQ-023 On accept (imem_req_valid && imem_req_ready), SHALL latch pc_current as req_pc and go to WAIT.
REQ-024 SHALL compute pc_stall = !(accept || branch_taken): the PC advances only on accept, and always loads a branch target.
REQ-025 In WAIT, on imem_rsp_valid with branch_taken=0, SHALL push {req_pc, imem_rsp_data, fault=0} and go to IDLE; the next request is issued no earlier than the following cycle.
REQ-026 In WAIT, on branch_taken with imem_rsp_valid=0, SHALL go to DROP.
REQ-027 In WAIT, on branch_taken with imem_rsp_valid=1 in the same cycle, SHALL discard the response and go to IDLE.
REQ-028 In DROP, the next imem_rsp_valid SHALL be discarded with a transition to IDLE; a further branch_taken in DROP SHALL keep the state in DROP.
REQ-029 In IDLE, if pc_current[1:0]!=0 or pc_current>=MAX_ADDR, and room exists, SHALL issue no request, push {pc_current, 32'h00000013, fault=1}, and go to FAULT.
REQ-030 In FAULT, SHALL hold pc_stall=1 and imem_req_valid=0 until branch_taken, then go to IDLE.
REQ-031 On branch_taken in any state, SHALL clear the buffer (count=0) at the clock edge; if_valid SHALL be 0 the following cycle.
REQ-032 A push or pop in the same cycle as branch_taken SHALL be suppressed.
REQ-033 The buffer SHALL be a circular FIFO with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-034 Simultaneous push and pop SHALL leave count unchanged.
REQ-035 The buffer SHALL never overflow: the request gating on count<FIFO_DEPTH with a single outstanding request guarantees room.
REQ-036 if_valid SHALL equal (count!=0), and if_instr, if_pc and if_fault SHALL reflect the head entry.
REQ-037 Pop SHALL occur on if_valid && if_ready.
REQ-038 if_instr, if_pc and if_fault SHALL remain stable while if_valid && !if_ready.

Reset
REQ-039 With rst_n=0 at a rising edge, SHALL set state=IDLE, count=0, and both FIFO pointers=0.
REQ-040 While rst_n=0, SHALL force imem_req_valid=0 and pc_stall=1; if_valid SHALL be 0 from the first edge with rst_n low.
REQ-041 Reset asserted in WAIT SHALL abandon the request; one stale response arriving after reset release SHALL be tolerated by treating an imem_rsp_valid in IDLE as discarded.

Verification
REQ-042 Basic fetch: pc=0x1000, ready=1, 1-cycle memory returning 0x00500093, if_ready=1 -> if_valid with if_pc=0x1000 and if_instr=0x00500093; pc_stall low exactly on the accept cycles.
REQ-043 Backpressure: if_ready=0 for 10 cycles -> after 2 entries (0x1000, 0x1004), imem_req_valid=0 and pc_stall=1; head held stable; release -> entries pop in order.
REQ-044 Flush in WAIT: branch_taken 1 cycle after accept, response 3 cycles later -> response discarded, count=0, next request uses the new pc_current (e.g. 0x1100).
REQ-045 Flush coincident with response: branch_taken and imem_rsp_valid in the same cycle -> no push, state IDLE next cycle.
REQ-046 Fault: pc_current=0x1002 -> no request, entry with if_fault=1, if_pc=0x1002, if_instr=0x00000013; pc_stall=1 until branch_taken.
REQ-047 Reset mid-operation: rst_n low for 1 cycle in WAIT -> state IDLE, if_valid=0, imem_req_valid=0 during reset; late response ignored.
